// File: rtl/ace_snoop_responder.sv
`default_nettype none
// ==========================================================================
// ace_snoop_responder: ACE AC/CR/CD snoop responder with tag lookup, line
// streaming through a 2-entry CD FIFO and a trailing cache state update.
// Revision: 1.0
// ==========================================================================
module ace_snoop_responder #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int LineBeats = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         ac_valid_i,
  output logic                         ac_ready_o,
  input  logic [AddrWidth-1:0]         ac_addr_i,
  input  logic [3:0]                   ac_snoop_i,
  input  logic [2:0]                   ac_prot_i,
  output logic                         cr_valid_o,
  input  logic                         cr_ready_i,
  output logic [4:0]                   cr_resp_o,
  output logic                         cd_valid_o,
  input  logic                         cd_ready_i,
  output logic [DataWidth-1:0]         cd_data_o,
  output logic                         cd_last_o,
  output logic                         lk_req_o,
  input  logic                         lk_gnt_i,
  output logic [AddrWidth-1:0]         lk_addr_o,
  input  logic                         lk_rvalid_i,
  input  logic                         lk_hit_i,
  input  logic                         lk_dirty_i,
  input  logic                         lk_shared_i,
  output logic                         rd_req_o,
  output logic [$clog2(LineBeats)-1:0] rd_beat_o,
  input  logic [DataWidth-1:0]         rd_data_i,
  output logic                         upd_valid_o,
  input  logic                         upd_ready_i,
  output logic                         upd_invalidate_o,
  output logic                         upd_clean_o,
  output logic                         upd_make_shared_o
);

  localparam int BeatW = $clog2(LineBeats);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    LK_RESP = 3'd2,
    CR      = 3'd3,
    DATA    = 3'd4,
    UPDATE  = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic [AddrWidth-1:0] addr_q;
  logic [3:0]           snoop_q;
  logic [2:0]           prot_q_unused;
  logic [4:0]           resp_q;
  logic                 inv_q, cln_q, mks_q;
  logic [BeatW:0]       rd_cnt;
  logic                 rd_inflight;
  logic [BeatW-1:0]     cd_cnt;
  logic [DataWidth-1:0] fifo_mem [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           fifo_cnt;

  logic dt, pd, is_sh, sup, act_inv, act_cln, act_mks;
  logic ac_hs, cr_hs, cd_pop, push, any_act;
  logic [2:0] occ_after;

  // Response/action decode from the latched snoop code and the lookup result.
  always_comb begin
    sup     = 1'b1;
    dt      = 1'b0;
    pd      = 1'b0;
    is_sh   = 1'b0;
    act_inv = 1'b0;
    act_cln = 1'b0;
    act_mks = 1'b0;
    case (snoop_q)
      4'b0000: begin dt = 1'b1; is_sh = 1'b1; end
      4'b0001, 4'b0010, 4'b0011: begin
        dt = 1'b1; pd = lk_dirty_i; is_sh = 1'b1;
        act_mks = 1'b1; act_cln = lk_dirty_i;
      end
      4'b0111: begin dt = 1'b1; pd = lk_dirty_i; act_inv = 1'b1; end
      4'b1001: begin dt = lk_dirty_i; pd = lk_dirty_i; act_inv = 1'b1; end
      4'b1000: begin dt = lk_dirty_i; pd = lk_dirty_i; is_sh = 1'b1; act_cln = lk_dirty_i; end
      4'b1101: act_inv = 1'b1;
      default: sup = 1'b0;
    endcase
  end

  assign ac_hs   = ac_valid_i && ac_ready_o;
  assign cr_hs   = cr_valid_o && cr_ready_i;
  assign cd_pop  = cd_valid_o && cd_ready_i;
  assign push    = rd_inflight;
  assign any_act = inv_q || cln_q || mks_q;

  assign ac_ready_o = (state == IDLE);
  assign lk_req_o   = (state == LOOKUP);
  assign lk_addr_o  = addr_q;
  assign cr_valid_o = (state == CR);
  assign cr_resp_o  = resp_q;

  // Occupancy counts the beat leaving this cycle so the line can stream 1 beat/cycle.
  assign occ_after = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, cd_pop};
  assign rd_req_o  = (state == DATA) && !rd_cnt[BeatW] && (occ_after < 3'd2);
  assign rd_beat_o = rd_cnt[BeatW-1:0];

  assign cd_valid_o = (fifo_cnt != 2'd0);
  assign cd_data_o  = fifo_mem[rd_ptr];
  assign cd_last_o  = cd_valid_o && (cd_cnt == BeatW'(LineBeats - 1));

  assign upd_valid_o       = (state == UPDATE);
  assign upd_invalidate_o  = (state == UPDATE) && inv_q;
  assign upd_clean_o       = (state == UPDATE) && cln_q;
  assign upd_make_shared_o = (state == UPDATE) && mks_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ac_hs) state_nxt = LOOKUP;
      LOOKUP:  if (lk_gnt_i) state_nxt = LK_RESP;
      LK_RESP: if (lk_rvalid_i) state_nxt = CR;
      CR: begin
        if (cr_hs) begin
          if (resp_q[0])    state_nxt = DATA;
          else if (any_act) state_nxt = UPDATE;
          else              state_nxt = IDLE;
        end
      end
      DATA:    if (cd_pop && cd_last_o) state_nxt = any_act ? UPDATE : IDLE;
      UPDATE:  if (upd_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      addr_q        <= '0;
      snoop_q       <= '0;
      prot_q_unused <= '0;
      resp_q        <= '0;
      inv_q         <= 1'b0;
      cln_q         <= 1'b0;
      mks_q         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ac_hs) begin
        addr_q        <= ac_addr_i;
        snoop_q       <= ac_snoop_i;
        prot_q_unused <= ac_prot_i;
      end
      if ((state == LK_RESP) && lk_rvalid_i) begin
        if (lk_hit_i && sup) begin
          resp_q <= {!lk_shared_i, is_sh, pd, 1'b0, dt};
          inv_q  <= act_inv;
          cln_q  <= act_cln;
          mks_q  <= act_mks;
        end else begin
          resp_q <= '0;
          inv_q  <= 1'b0;
          cln_q  <= 1'b0;
          mks_q  <= 1'b0;
        end
      end
    end
  end

  // Read issue and CD FIFO; counters restart on every CR handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt      <= '0;
      rd_inflight <= 1'b0;
      cd_cnt      <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      rd_inflight <= rd_req_o;
      if (cr_hs) begin
        rd_cnt <= '0;
        cd_cnt <= '0;
      end else begin
        if (rd_req_o) rd_cnt <= rd_cnt + 1'b1;
        if (cd_pop)   cd_cnt <= cd_cnt + 1'b1;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= rd_data_i;
        wr_ptr           <= ~wr_ptr;
      end
      if (cd_pop) rd_ptr <= ~rd_ptr;
      case ({push, cd_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ace_snoop_responder.sv
`default_nettype none
// Directed, table-driven bench for ace_snoop_responder: reference lookup/data
// models plus a per-transaction observer compared against hand-derived vectors.
module tb_ace_snoop_responder;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LB = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          ac_valid_i, ac_ready_o;
  logic [AW-1:0] ac_addr_i;
  logic [3:0]    ac_snoop_i;
  logic [2:0]    ac_prot_i;
  logic          cr_valid_o, cr_ready_i;
  logic [4:0]    cr_resp_o;
  logic          cd_valid_o, cd_ready_i, cd_last_o;
  logic [DW-1:0] cd_data_o;
  logic          lk_req_o, lk_gnt_i, lk_rvalid_i, lk_hit_i, lk_dirty_i, lk_shared_i;
  logic [AW-1:0] lk_addr_o;
  logic          rd_req_o;
  logic [1:0]    rd_beat_o;
  logic [DW-1:0] rd_data_i;
  logic          upd_valid_o, upd_ready_i, upd_invalidate_o, upd_clean_o, upd_make_shared_o;

  ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineBeats(LB)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
    .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .lk_req_o(lk_req_o), .lk_gnt_i(lk_gnt_i), .lk_addr_o(lk_addr_o), .lk_rvalid_i(lk_rvalid_i),
    .lk_hit_i(lk_hit_i), .lk_dirty_i(lk_dirty_i), .lk_shared_i(lk_shared_i),
    .rd_req_o(rd_req_o), .rd_beat_o(rd_beat_o), .rd_data_i(rd_data_i),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i),
    .upd_invalidate_o(upd_invalidate_o), .upd_clean_o(upd_clean_o),
    .upd_make_shared_o(upd_make_shared_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] snoop;
    logic       hit, dirty, shared;
    int         mode;   // 0: all ready, 1: toggling readies/grant, 2: long CD stall
    logic [4:0] resp;
    logic       inv, cln, mks;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lookup and data-array models: result/data one cycle after grant/read.
  logic          rd_pend, lk_pend;
  logic [1:0]    rd_pend_beat;
  logic [DW-1:0] data_base;
  logic [AW-1:0] lk_addr_seen;
  int            n_lookups = 0;
  int            n_reads   = 0;

  always @(negedge clk) begin
    #1;
    if (!rst_ni) begin
      rd_pend     = 1'b0;
      lk_pend     = 1'b0;
      rd_data_i   = '0;
      lk_rvalid_i = 1'b0;
    end else begin
      rd_data_i    = rd_pend ? data_base + 64'(rd_pend_beat) : '0;
      lk_rvalid_i  = lk_pend;
      rd_pend      = rd_req_o;
      rd_pend_beat = rd_beat_o;
      lk_pend      = lk_req_o && lk_gnt_i;
      if (rd_req_o) n_reads++;
      if (lk_req_o && lk_gnt_i) begin
        n_lookups++;
        lk_addr_seen = lk_addr_o;
      end
    end
  end

  logic          cr_seen, upd_seen, timeout;
  logic [4:0]    obs_resp;
  logic          obs_inv, obs_cln, obs_mks;
  logic [DW-1:0] beat_q[$];
  logic          last_q[$];
  int            ac_early, first_cd, last_cd, cr_cyc, last_hs, end_cyc;

  task automatic issue(input logic [3:0] sn, input logic [AW-1:0] a, input bit hold);
    int n;
    n = 0;
    ac_snoop_i = sn;
    ac_addr_i  = a;
    ac_prot_i  = 3'b010;
    ac_valid_i = 1'b1;
    while (!ac_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ac_accept_timeout", 64'(n >= 50), 64'd0);
    @(negedge clk);
    if (!hold) ac_valid_i = 1'b0;
  endtask

  // Observe one transaction from just after the AC handshake until IDLE returns.
  task automatic collect(input int mode);
    int n, dcyc;
    n = 0; dcyc = 0;
    cr_seen = 0; upd_seen = 0; timeout = 0; obs_resp = '0;
    obs_inv = 0; obs_cln = 0; obs_mks = 0;
    beat_q.delete(); last_q.delete();
    ac_early = 0; first_cd = -1; last_cd = -1; cr_cyc = -1; last_hs = -1; end_cyc = -1;
    while (1) begin
      if (n >= 300) begin timeout = 1; break; end
      if (cr_seen && ac_ready_o) begin end_cyc = cyc; break; end
      if (ac_ready_o) ac_early++;
      cr_ready_i  = (mode == 1) ? (n % 2 == 1) : 1'b1;
      upd_ready_i = (mode != 0) ? (n % 3 == 2) : 1'b1;
      cd_ready_i  = (mode == 1) ? (n % 2 == 0) : (mode == 2) ? (dcyc > 12) : 1'b1;
      lk_gnt_i    = (mode == 1) ? (n % 2 == 1) : 1'b1;
      if (cr_valid_o && cr_ready_i) begin
        obs_resp = cr_resp_o; cr_seen = 1; cr_cyc = cyc; last_hs = cyc;
      end
      if (cd_valid_o && cd_ready_i) begin
        beat_q.push_back(cd_data_o);
        last_q.push_back(cd_last_o);
        if (first_cd < 0) first_cd = cyc;
        last_cd = cyc; last_hs = cyc;
      end
      if (upd_valid_o && upd_ready_i) begin
        upd_seen = 1; obs_inv = upd_invalidate_o; obs_cln = upd_clean_o;
        obs_mks = upd_make_shared_o; last_hs = cyc;
      end
      if (cr_seen) dcyc++;
      @(negedge clk);
      n++;
    end
    cr_ready_i = 1'b1; cd_ready_i = 1'b1; upd_ready_i = 1'b1; lk_gnt_i = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input logic [AW-1:0] addr, input logic [DW-1:0] base,
                         input bit hold);
    int lk0, rd0, nb;
    logic any;
    lk_hit_i = v.hit; lk_dirty_i = v.dirty; lk_shared_i = v.shared;
    data_base = base;
    lk0 = n_lookups; rd0 = n_reads;
    issue(v.snoop, addr, hold);
    collect(v.mode);
    nb  = v.resp[0] ? LB : 0;
    any = v.inv | v.cln | v.mks;
    chk("timeout", 64'(timeout), 64'd0);
    chk("cr_resp", 64'(obs_resp), 64'(v.resp));
    chk("beat_count", 64'(beat_q.size()), 64'(nb));
    for (int i = 0; i < beat_q.size(); i++) begin
      chk("beat_data", beat_q[i], base + 64'(i));
      chk("beat_last", 64'(last_q[i]), 64'(i == LB - 1));
    end
    chk("rd_req_count", 64'(n_reads - rd0), 64'(nb));
    chk("upd_seen", 64'(upd_seen), 64'(any));
    if (any) chk("upd_flags", {61'd0, obs_inv, obs_cln, obs_mks}, {61'd0, v.inv, v.cln, v.mks});
    chk("lookups", 64'(n_lookups - lk0), 64'd1);
    chk("lk_addr", lk_addr_seen, addr);
    chk("ac_ready_busy", 64'(ac_early), 64'd0);
    chk("idle_after_last", 64'(end_cyc - last_hs), 64'd1);
    if (v.mode == 0 && nb > 0) begin
      chk("first_cd_latency", 64'(first_cd - cr_cyc), 64'd3);
      chk("cd_stream", 64'(last_cd - first_cd), 64'(LB - 1));
    end
  endtask

  vec_t vecs[12];
  vec_t va;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, bad_idle;
    rst_ni = 1'b0;
    ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0;
    cr_ready_i = 1'b1; cd_ready_i = 1'b1; upd_ready_i = 1'b1; lk_gnt_i = 1'b1;
    lk_hit_i = 1'b0; lk_dirty_i = 1'b0; lk_shared_i = 1'b0; data_base = '0;
    //          snoop    h     d     s    mode resp       inv   cln   mks
    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 0, 5'b00000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0001, 1'b1, 1'b1, 1'b0, 0, 5'b11101, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{4'b0111, 1'b1, 1'b0, 1'b1, 1, 5'b00001, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'b1001, 1'b1, 1'b0, 1'b0, 0, 5'b10000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 0, 5'b11001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b1000, 1'b1, 1'b1, 1'b1, 1, 5'b01101, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{4'b1101, 1'b1, 1'b1, 1'b0, 0, 5'b10000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 0, 5'b00000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'b1001, 1'b1, 1'b1, 1'b1, 0, 5'b00101, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4'b0011, 1'b1, 1'b0, 1'b0, 1, 5'b11001, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{4'b0010, 1'b1, 1'b1, 1'b1, 0, 5'b01101, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{4'b1000, 1'b1, 1'b0, 1'b0, 0, 5'b11000, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_valids", {58'd0, cr_valid_o, cd_valid_o, upd_valid_o, rd_req_o, lk_req_o, cd_last_o}, 64'd0);
    chk("reset_resp", 64'(cr_resp_o), 64'd0);
    chk("reset_cd_data", cd_data_o, 64'd0);
    rst_ni = 1'b1;
    chk("ac_ready_after_reset", 64'(ac_ready_o), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_vec(vecs[i], 64'h1000 + 64'(i) * 64'h40, (64'(i) << 32) | 64'hA0, 1'b0);

    // Second snoop held on AC while the first one's CD channel is stalled.
    va = vecs[1];
    va.mode = 2;
    run_vec(va, 64'h2000, 64'hE0, 1'b1);
    run_vec(vecs[1], 64'h2000, 64'hF0, 1'b0);

    // Reset while beat 2 of the line is being presented.
    lk_hit_i = 1'b1; lk_dirty_i = 1'b1; lk_shared_i = 1'b0; data_base = 64'hB0;
    issue(4'b0001, 64'h3000, 1'b0);
    n = 0; nb = 0;
    while (n < 100 && !(cd_valid_o && nb == 2)) begin
      if (cd_valid_o) nb++;
      @(negedge clk);
      n++;
    end
    chk("reached_beat2", 64'(nb), 64'd2);
    rst_ni = 1'b0;
    #1;
    chk("midrst_valids", {58'd0, cr_valid_o, cd_valid_o, upd_valid_o, rd_req_o, lk_req_o, cd_last_o}, 64'd0);
    chk("midrst_resp", 64'(cr_resp_o), 64'd0);
    chk("midrst_cd_data", cd_data_o, 64'd0);
    chk("midrst_lk_addr", lk_addr_o, 64'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    chk("ac_ready_after_midrst", 64'(ac_ready_o), 64'd1);
    bad_idle = 0;
    repeat (5) begin
      @(negedge clk);
      if (upd_valid_o || !ac_ready_o) bad_idle++;
    end
    chk("idle_after_midrst", 64'(bad_idle), 64'd0);
    run_vec(vecs[1], 64'h4000, 64'hC0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
